// File: rtl/tile_rom_arbiter.sv
// Two-port round-robin arbiter for the shared 64x32 tile bitmap ROM.
// One fetch per 2 cycles: IDLE latches the winner's address, FETCH captures the ROM row.
module tile_rom_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  tile0,
  input  logic                  tile1,
  input  logic [4:0]            row0,
  input  logic [4:0]            row1,
  input  logic                  hflip0,
  input  logic                  hflip1,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  valid0,
  output logic                  valid1,
  output logic                  busy
);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_FETCH = 1'b1;

  logic                  state;
  logic                  owner;
  logic                  flip_q;
  logic                  last_served;
  logic                  win;
  logic                  w_tile;
  logic [4:0]            w_row;
  logic                  w_flip;
  logic [DATA_WIDTH-1:0] rev;

  // Contested cycle goes to the port that was not served last.
  always_comb begin
    win = req1;
    if (req0 && req1) win = ~last_served;
    w_tile = win ? tile1  : tile0;
    w_row  = win ? row1   : row0;
    w_flip = win ? hflip1 : hflip0;
  end

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_rev
    assign rev[i] = rom_data[DATA_WIDTH-1-i];
  end

  assign busy = (state == S_FETCH);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      flip_q      <= 1'b0;
      last_served <= 1'b1;
      rom_addr    <= '0;
      rd_data     <= '0;
      valid0      <= 1'b0;
      valid1      <= 1'b0;
    end else if (state == S_IDLE) begin
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      if (req0 || req1) begin
        rom_addr <= ADDR_WIDTH'({w_tile, w_row});
        owner    <= win;
        flip_q   <= w_flip;
        state    <= S_FETCH;
      end
    end else begin
      rd_data     <= flip_q ? rev : rom_data;
      valid0      <= ~owner;
      valid1      <= owner;
      last_served <= owner;
      state       <= S_IDLE;
    end
  end

endmodule
